// File: rtl/alu_arbiter_8bit.sv
// Two-port arbiter sharing one 8-bit ALU through an IDLE/EXEC/RESP FSM.
// Define ALU_ARB_OPCHECK_EN to flag opcode 3'b111 as illegal instead of executing it.
module alu_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [2:0] sel,
  output logic [7:0] out,
  output logic       carry,
  output logic       zeroFlag,
  output logic       negFlag,
  output logic       OverFlowFlag
);
  logic signed [8:0] a_s;
  logic signed [8:0] b_s;
  logic signed [8:0] sum_s;
  logic signed [8:0] dif_s;
  logic        [8:0] add_u;
  logic        [8:0] sub_u;

  assign a_s   = {A[7], A};
  assign b_s   = {B[7], B};
  assign sum_s = a_s + b_s;
  assign dif_s = a_s - b_s;
  assign add_u = {1'b0, A} + {1'b0, B};
  assign sub_u = {1'b0, A} - {1'b0, B};

  // carry is the unsigned carry-out (borrow for SUB, shifted-out bit for shifts)
  always_comb begin
    out          = 8'd0;
    carry        = 1'b0;
    OverFlowFlag = 1'b0;
    case (sel)
      3'b000: begin
        out          = add_u[7:0];
        carry        = add_u[8];
        OverFlowFlag = sum_s[8] ^ sum_s[7];
      end
      3'b001: begin
        out          = sub_u[7:0];
        carry        = sub_u[8];
        OverFlowFlag = dif_s[8] ^ dif_s[7];
      end
      3'b010: out = A & B;
      3'b011: out = A | B;
      3'b100: out = A ^ B;
      3'b101: out = ~A;
      3'b110: begin
        out   = {A[6:0], 1'b0};
        carry = A[7];
      end
      default: begin
        out   = {1'b0, A[7:1]};
        carry = A[0];
      end
    endcase
    zeroFlag = (out == 8'd0);
    negFlag  = out[7];
  end
endmodule

module alu_arbiter_8bit #(
  parameter bit FAIR_RR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [2:0] req0_sel,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [2:0] req1_sel,
  output logic       resp0_valid,
  input  logic       resp0_ready,
  output logic [7:0] resp0_result,
  output logic [3:0] resp0_flags,
  output logic       resp0_err,
  output logic       resp1_valid,
  input  logic       resp1_ready,
  output logic [7:0] resp1_result,
  output logic [3:0] resp1_flags,
  output logic       resp1_err,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state_q, state_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic       gnt_q, gnt_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] result_q, result_d;
  logic [3:0] flags_q, flags_d;
  logic       rst_dly_q;
`ifdef ALU_ARB_OPCHECK_EN
  logic       err_q, err_d;
`endif

  logic [7:0] alu_out;
  logic       alu_c, alu_z, alu_n, alu_v;
  logic       out_en;
  logic       pick;
  logic       accept;
  logic       resp_hs;

  alu_8bit u_alu (
    .A            (a_q),
    .B            (b_q),
    .sel          (sel_q),
    .out          (alu_out),
    .carry        (alu_c),
    .zeroFlag     (alu_z),
    .negFlag      (alu_n),
    .OverFlowFlag (alu_v)
  );

  // Outputs are silenced while rst is high and for one cycle after it drops
  assign out_en  = !rst && !rst_dly_q;
  assign accept  = out_en && (state_q == IDLE) && (req0_valid || req1_valid);
  assign resp_hs = (state_q == RESP) && (gnt_q ? resp1_ready : resp0_ready);

  always_comb begin
    pick = rr_ptr_q;
    if (req0_valid && !req1_valid) pick = 1'b0;
    else if (req1_valid && !req0_valid) pick = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    result_d = result_q;
    flags_d  = flags_q;
`ifdef ALU_ARB_OPCHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          gnt_d   = pick;
          a_d     = pick ? req1_a : req0_a;
          b_d     = pick ? req1_b : req0_b;
          sel_d   = pick ? req1_sel : req0_sel;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_out;
        flags_d  = {alu_v, alu_n, alu_z, alu_c};
`ifdef ALU_ARB_OPCHECK_EN
        err_d    = 1'b0;
        if (sel_q == 3'b111) begin
          result_d = 8'd0;
          flags_d  = 4'd0;
          err_d    = 1'b1;
        end
`endif
        state_d = RESP;
      end
      RESP: begin
        if (resp_hs) begin
          rr_ptr_d = FAIR_RR ? !gnt_q : 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 1'b0;
      gnt_q     <= 1'b0;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      sel_q     <= 3'd0;
      result_q  <= 8'd0;
      flags_q   <= 4'd0;
      rst_dly_q <= 1'b1;
`ifdef ALU_ARB_OPCHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sel_q     <= sel_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      rst_dly_q <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign req0_ready   = accept && !pick;
  assign req1_ready   = accept && pick;
  assign busy         = out_en && (state_q != IDLE);
  assign resp0_valid  = out_en && (state_q == RESP) && !gnt_q;
  assign resp1_valid  = out_en && (state_q == RESP) && gnt_q;
  assign resp0_result = resp0_valid ? result_q : 8'd0;
  assign resp1_result = resp1_valid ? result_q : 8'd0;
  assign resp0_flags  = resp0_valid ? flags_q : 4'd0;
  assign resp1_flags  = resp1_valid ? flags_q : 4'd0;
`ifdef ALU_ARB_OPCHECK_EN
  assign resp0_err    = resp0_valid && err_q;
  assign resp1_err    = resp1_valid && err_q;
`else
  assign resp0_err    = 1'b0;
  assign resp1_err    = 1'b0;
`endif
endmodule
